// File: rtl/mux_scan_sched.sv
// Multiplexed-channel scan scheduler: emits a header byte, then one byte per channel.
// Optional SCAN_AVG_EN averages 4 ADC samples per channel instead of using a single sample.
module mux_scan_sched #(
  parameter int unsigned NUM_CH     = 24,
  parameter int unsigned SETTLE_CYC = 500,
  parameter logic [7:0]  HDR_BYTE   = 8'hAA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  input  logic        fifo_full,
  output logic [5:0]  addr,
  output logic        fifo_wr,
  output logic [7:0]  fifo_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, HDR, SETTLE, ACQ, WRITE, NEXT} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [5:0]  LAST_CH     = 6'(NUM_CH - 1);

  state_t      state;
  logic        start_q;
  logic [15:0] cnt;
  logic [7:0]  ch_byte;

`ifdef SCAN_AVG_EN
  logic [13:0] sum;
  logic [1:0]  nsamp;
  logic [13:0] sum_nxt;
  assign sum_nxt = sum + {2'b00, adc_data};
`else
  logic unused_lsb;
  assign unused_lsb = ^adc_data[3:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      cnt        <= '0;
      ch_byte    <= '0;
      addr       <= '0;
      fifo_wr    <= 1'b0;
      fifo_data  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SCAN_AVG_EN
      sum        <= '0;
      nsamp      <= '0;
`endif
    end else begin
      start_q    <= start;
      fifo_wr    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            state <= HDR;
            busy  <= 1'b1;
            addr  <= '0;
          end
        end
        HDR: begin
          if (!fifo_full) begin
            fifo_wr   <= 1'b1;
            fifo_data <= HDR_BYTE;
            cnt       <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          // adc_valid is deliberately ignored until the mux has settled
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ACQ;
`ifdef SCAN_AVG_EN
            sum   <= '0;
            nsamp <= '0;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACQ: begin
          if (adc_valid) begin
`ifdef SCAN_AVG_EN
            sum   <= sum_nxt;
            nsamp <= nsamp + 2'd1;
            if (nsamp == 2'd3) begin
              ch_byte <= sum_nxt[13:6];
              state   <= WRITE;
            end
`else
            ch_byte <= adc_data[11:4];
            state   <= WRITE;
`endif
          end
        end
        WRITE: begin
          if (!fifo_full) begin
            fifo_wr   <= 1'b1;
            fifo_data <= ch_byte;
            state     <= NEXT;
          end
        end
        NEXT: begin
          if (addr == LAST_CH) begin
            addr       <= '0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            addr  <= addr + 6'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sched.sv
// Self-checking bench for mux_scan_sched: table-driven frames plus hand-written corner sequences.
// Expected bytes are queued when a frame is requested and popped on each fifo_wr.
module tb_mux_scan_sched;
  localparam int unsigned NCH = 3;
  localparam int unsigned SET = 4;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        fifo_full = 1'b0;
  logic [5:0]  addr;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic        busy;
  logic        frame_done;

  mux_scan_sched #(.NUM_CH(NCH), .SETTLE_CYC(SET), .HDR_BYTE(8'hAA)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .adc_valid(adc_valid),
    .adc_data(adc_data), .fifo_full(fifo_full), .addr(addr), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;

  typedef struct {logic [7:0] data; logic [5:0] addr; bit ramp; bit hdr;} exp_t;
  exp_t sb[$];

  typedef struct {logic [11:0] adc; logic [7:0] byte_exp;} vec_t;
  vec_t vecs[4];

  // 0: periodic valid every 10 cycles with adc_val; 1: valid every cycle, data ramps with time; 3: hands-off
  int          adc_mode = 0;
  logic [11:0] adc_val = '0;
  int          adc_tick = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic logic [7:0] ramp_byte(longint t);
    return 8'((t / P) % 256);
  endfunction

  // Byte captured k edges after the write observed at t0, with ramping data
  function automatic logic [7:0] ramp_exp(longint t0, int k);
    logic [13:0] s;
`ifdef SCAN_AVG_EN
    int n = 4;
`else
    int n = 1;
`endif
    s = '0;
    for (int i = 0; i < n; i++)
      s = s + {2'b00, ramp_byte(t0 + longint'(k - 1 + i) * P), 4'h5};
`ifdef SCAN_AVG_EN
    return s[13:6];
`else
    return s[11:4];
`endif
  endfunction

  always @(negedge clk) begin
    case (adc_mode)
      0: begin
        adc_tick  = (adc_tick + 1) % 10;
        adc_valid = (adc_tick == 0);
        adc_data  = adc_val;
      end
      1: begin
        adc_valid = 1'b1;
        adc_data  = {ramp_byte($time), 4'h5};
      end
      default: ;
    endcase
  end

  longint last_wr_t = 0;
  bit     last_hdr = 1'b0;

  always @(negedge clk) begin
    exp_t        e;
    logic [7:0]  expd;
    if (frame_done) done_count++;
    if (fifo_wr) begin
      wr_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got data %0h addr %0d expected no write", fifo_data, addr);
        last_hdr = 1'b0;
      end else begin
        e = sb.pop_front();
        expd = e.ramp ? ramp_exp(last_wr_t, last_hdr ? int'(SET) + 1 : int'(SET) + 2) : e.data;
        check("wr_data", {24'd0, fifo_data}, {24'd0, expd});
        check("wr_addr", {26'd0, addr}, {26'd0, e.addr});
        last_hdr = e.hdr;
      end
      last_wr_t = $time;
    end
  end

  task automatic push_frame(logic [7:0] b, bit ramp);
    sb.push_back(exp_t'{8'hAA, 6'd0, 1'b0, 1'b1});
    for (int c = 0; c < int'(NCH); c++) sb.push_back(exp_t'{b, 6'(c), ramp, 1'b0});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!frame_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) timeout_fail(name);
  endtask

  task automatic wait_addr(logic [5:0] a, string name);
    int n = 0;
    while (addr != a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (addr != a) timeout_fail(name);
  endtask

  // Runs one frame and checks completion bookkeeping
  task automatic run_frame(logic [7:0] b, bit ramp, string name);
    int w0 = wr_count;
    int d0 = done_count;
    push_frame(b, ramp);
    pulse_start();
    check({name, "_busy_set"}, {31'd0, busy}, 32'd1);
    wait_done(name);
    @(negedge clk);
    check({name, "_busy_clr"}, {31'd0, busy}, 32'd0);
    check({name, "_addr_wrap"}, {26'd0, addr}, 32'd0);
    check({name, "_writes"}, wr_count - w0, NCH + 1);
    check({name, "_dones"}, done_count - d0, 32'd1);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    int viol;
    int w0;
    int d0;
    int n;

    vecs[0] = '{12'hABC, 8'hAB};
    vecs[1] = '{12'h000, 8'h00};
    vecs[2] = '{12'hFFF, 8'hFF};
    vecs[3] = '{12'h5A3, 8'h5A};

    #1;
    check("rst_addr", {26'd0, addr}, 32'd0);
    check("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    check("rst_fifo_data", {24'd0, fifo_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      adc_val = vecs[i].adc;
      run_frame(vecs[i].byte_exp, 1'b0, "table");
    end

    // adc_valid held high throughout SETTLE: capture must be the first ACQ-cycle sample
    adc_mode = 1;
    run_frame(8'h00, 1'b1, "settle_ignore");
    adc_mode = 0;

    // Downstream full while channel 1 is being written
    adc_val = 12'h3C1;
    w0 = wr_count;
    push_frame(8'h3C, 1'b0);
    pulse_start();
    wait_addr(6'd1, "full_addr1");
    fifo_full = 1'b1;
    viol = 0;
    repeat (35) begin
      @(negedge clk);
      if (fifo_wr || addr != 6'd1) viol++;
    end
    fifo_full = 1'b0;
    check("full_stall", viol, 32'd0);
    wait_done("full_frame");
    @(negedge clk);
    check("full_writes", wr_count - w0, NCH + 1);
    check("full_sb_empty", sb.size(), 32'd0);

    // Start edge while busy must be dropped
    adc_val = 12'h123;
    w0 = wr_count;
    d0 = done_count;
    push_frame(8'h12, 1'b0);
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done("restart_frame");
    repeat (60) @(negedge clk);
    check("restart_writes", wr_count - w0, NCH + 1);
    check("restart_dones", done_count - d0, 32'd1);
    adc_val = 12'h456;
    run_frame(8'h45, 1'b0, "after_done");

    // Reset pulse during SETTLE of channel 2
    adc_val = 12'h770;
    w0 = wr_count;
    d0 = done_count;
    push_frame(8'h77, 1'b0);
    pulse_start();
    wait_addr(6'd2, "rst_addr2");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_addr", {26'd0, addr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    check("midrst_fifo_data", {24'd0, fifo_data}, 32'd0);
    check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_writes", wr_count - w0, 32'd3);
    check("midrst_dones", done_count - d0, 32'd0);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);
    adc_val = 12'h9E0;
    run_frame(8'h9E, 1'b0, "post_reset");

`ifdef SCAN_AVG_EN
    // Four samples 100,200,300,400 averaged into 8'h28
    adc_mode = 3;
    adc_valid = 1'b0;
    push_frame(8'h28, 1'b0);
    pulse_start();
    n = 0;
    while (!fifo_wr && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fifo_wr) timeout_fail("avg_hdr");
    repeat (SET) @(negedge clk);
    adc_valid = 1'b1;
    adc_data = 12'h100;
    @(negedge clk) adc_data = 12'h200;
    @(negedge clk) adc_data = 12'h300;
    @(negedge clk) adc_data = 12'h400;
    @(negedge clk) adc_valid = 1'b0;
    adc_val = 12'h280;
    adc_mode = 0;
    wait_done("avg_frame");
    @(negedge clk);
    check("avg_sb_empty", sb.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mux_scan_sched.md
MUX_SCAN_SCHED -- requirements
Module: mux_scan_sched

Interface
REQ-001 Parameter NUM_CH, default 24, number of channels scanned per frame (1..64).
REQ-002 Parameter SETTLE_CYC, default 500, clk cycles of mux settling after an address change (1..65535).
REQ-003 Parameter HDR_BYTE, default 8'hAA, frame header byte.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  frame request; rising edge detected internally.
REQ-007 adc_valid  in  1  one-cycle strobe, adc_data valid.
REQ-008 adc_data  in  12  ADC quantised sample.
REQ-009 fifo_full  in  1  downstream byte FIFO full.
REQ-010 addr  out  6  mux channel address driven to the polling block.
REQ-011 fifo_wr  out  1  one-cycle write strobe.
REQ-012 fifo_data  out  8  byte written on fifo_wr.
REQ-013 busy  out  1  high from frame start until frame_done.
REQ-014 frame_done  out  1  one-cycle pulse after the last byte of a frame is written.

Function
REQ-015 States: IDLE, HDR, SETTLE, ACQ, WRITE, NEXT; the block SHALL occupy exactly one state per cycle.
REQ-016 IDLE: rising edge of start (start=1, previous start=0) SHALL move the block to HDR the next cycle, set busy, and set addr=0.
REQ-017 HDR: the block SHALL pulse fifo_wr with fifo_data=HDR_BYTE when fifo_full=0, then go to SETTLE; while fifo_full=1 it SHALL hold in HDR with fifo_wr=0.
REQ-018 SETTLE: a 16-bit counter SHALL count SETTLE_CYC cycles from entry; adc_valid during SETTLE SHALL be ignored; on expiry go to ACQ.
REQ-019 ACQ: the first adc_valid SHALL latch adc_data[11:4] as the channel byte and move to WRITE; no timeout applies.
REQ-020 WRITE: the block SHALL issue fifo_wr for one cycle with the latched byte when fifo_full=0; otherwise it SHALL stall with fifo_wr=0; bytes are never dropped.
REQ-021 NEXT: if addr<NUM_CH-1, addr SHALL increment by 1 and go to SETTLE; if addr=NUM_CH-1, addr SHALL wrap to 0, frame_done SHALL pulse, busy SHALL clear, and go to IDLE.
REQ-022 start edges while busy=1 SHALL be ignored, not queued.
REQ-023 addr SHALL change only on entry to HDR or in NEXT; it SHALL be stable throughout SETTLE, ACQ and WRITE.
REQ-024 A frame SHALL produce exactly NUM_CH+1 fifo_wr pulses, header first, channel order 0..NUM_CH-1.
REQ-025 adc_valid coincident with the ACQ-entry cycle SHALL be accepted.

Reset
REQ-026 While reset_n=0: state=IDLE, addr=0, fifo_wr=0, fifo_data=0, busy=0, frame_done=0, counters=0, start-edge register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with no further writes; a new frame SHALL require a fresh start edge after release.

Configuration
REQ-028 Macro SCAN_AVG_EN defined: ACQ SHALL accumulate 4 consecutive adc_valid samples in a 14-bit sum, and the channel byte SHALL be sum[13:6].
REQ-029 SCAN_AVG_EN undefined: single-sample behaviour per REQ-019; no accumulator logic is synthesised.

Verification
REQ-030 NUM_CH=3, SETTLE_CYC=4, fifo_full=0, adc_valid every 10 cycles with adc_data=12'hABC, one start pulse -> bytes AA,AB,AB,AB; addr steps 0,1,2,0; one frame_done; busy cleared.
REQ-031 adc_valid held high every cycle during SETTLE -> no capture until the counter expires; the captured byte is the first ACQ-cycle sample.
REQ-032 fifo_full=1 for 20 cycles during WRITE of ch1 -> fifo_wr stays 0, addr stays 1, the byte is written once after full drops, and the total is NUM_CH+1 writes.
REQ-033 Second start edge mid-frame -> ignored; exactly one frame is emitted; a start edge after frame_done starts a new frame.
REQ-034 reset_n pulsed low during SETTLE of ch2 -> all outputs are at reset values within the same cycle, and no writes follow until the next start.
REQ-035 SCAN_AVG_EN, samples 12'h100,12'h200,12'h300,12'h400 -> channel byte 8'h28.
